alu_mc: RTL

Parametrised, registered successor to the single-cycle datapath ALU. Adds a WIDTH parameter, signed compare and arithmetic shift, XOR, carry/overflow flags, and an iterative shift-add multiplier. It sits between register-file read and writeback and is wrapped in valid/ready handshakes, so the decode stage can stall on multi-cycle operations.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mul_iter.sv | 64 ++++++
 rtl/alu_mc.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and op classification for the
// multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_NOT     = 4'b0010;
  localparam logic [3:0] ALU_SLL     = 4'b0011;
  localparam logic [3:0] ALU_SRL     = 4'b0100;
  localparam logic [3:0] ALU_AND     = 4'b0101;
  localparam logic [3:0] ALU_OR      = 4'b0110;
  localparam logic [3:0] ALU_SLTU    = 4'b0111;
  localparam logic [3:0] ALU_PACK_LO = 4'b1000;
  localparam logic [3:0] ALU_PACK_HI = 4'b1001;
  localparam logic [3:0] ALU_SRA     = 4'b1010;
  localparam logic [3:0] ALU_SLT     = 4'b1011;
  localparam logic [3:0] ALU_XOR     = 4'b1100;
  localparam logic [3:0] ALU_MUL     = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    HOLD = 2'b10
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == ALU_MUL);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
// done is asserted during the final step; product is the value after that step.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic             active_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] step_sum;

  // Accumulator value once the current step's partial product is added
  always_comb begin
    step_sum = acc_r;
    if (mplier_r[0]) begin
      step_sum = acc_r + mcand_r;
    end else begin
      step_sum = acc_r;
    end
  end

  assign done    = active_r && (count_r == {CW{1'b0}});
  assign product = step_sum;

  // Operand load on start, then one shift-add step per cycle until count expires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
      count_r  <= {CW{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
    end else if (start) begin
      active_r <= 1'b1;
      count_r  <= CW'(WIDTH - 1);
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= a;
      mplier_r <= b;
    end else if (active_r) begin
      acc_r    <= step_sum;
      mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      if (count_r == {CW{1'b0}}) begin
        active_r <= 1'b0;
      end else begin
        count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Registered ALU with valid/ready handshakes: single-cycle simple ops and an
// iterative multiplier, with result and flags held until the consumer takes them.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  state_t           state_r;
  state_t           next_state;
  logic             accept;
  logic             mul_op;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             carry_r;
  logic             overflow_r;
  logic             out_valid_r;

  assign mul_op = is_multicycle(alu_control);
  assign accept = in_valid && in_ready;
  assign shamt  = b[SHW-1:0];

  // Carry out of the subtract is NOT borrow since it is formed as a + ~b + 1
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);

  // Simple-op datapath; reserved and multi-cycle codes fall through to add
  always_comb begin
    alu_res = sum_ext[WIDTH-1:0];
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_control)
      ALU_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = sub_ovf;
      end
      ALU_NOT:     alu_res = ~a;
      ALU_SLL:     alu_res = a << shamt;
      ALU_SRL:     alu_res = a >> shamt;
      ALU_SRA:     alu_res = $signed(a) >>> shamt;
      ALU_AND:     alu_res = a & b;
      ALU_OR:      alu_res = a | b;
      ALU_XOR:     alu_res = a ^ b;
      ALU_SLTU:    alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLT:     alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_PACK_LO: alu_res = {{(WIDTH-16){1'b0}}, b[7:0], a[7:0]};
      ALU_PACK_HI: alu_res = {{(WIDTH-16){1'b0}}, a[15:8], b[7:0]};
      default: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = add_ovf;
      end
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && mul_op),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Acceptance depends only on state and consumer readiness
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    next_state = state_r;
    case (state_r)
      IDLE: begin
        if (accept) begin
          next_state = mul_op ? BUSY : HOLD;
        end else begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        if (mul_done) begin
          next_state = HOLD;
        end else begin
          next_state = BUSY;
        end
      end
      HOLD: begin
        if (out_ready && in_valid) begin
          next_state = mul_op ? BUSY : HOLD;
        end else if (out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = HOLD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state;
    end
  end

  // Result and flags load together from one op and freeze otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (next_state == HOLD);
      if (accept && !mul_op) begin
        result_r   <= alu_res;
        zero_r     <= (alu_res == {WIDTH{1'b0}});
        carry_r    <= alu_c;
        overflow_r <= alu_v;
      end else if ((state_r == BUSY) && mul_done) begin
        result_r   <= mul_product;
        zero_r     <= (mul_product == {WIDTH{1'b0}});
        carry_r    <= 1'b0;
        overflow_r <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;
  assign carry     = carry_r;
  assign overflow  = overflow_r;

endmodule
